// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, NOP encoding and fetch FSM states.
// Used by fetch_unit and by control_unit on the decode side.
package isa_pkg;

    localparam logic [4:0] OP_SETC = 5'b00001;
    localparam logic [4:0] OP_LDM  = 5'b00111;
    localparam logic [4:0] OP_STD  = 5'b01110;
    localparam logic [4:0] OP_LDD  = 5'b01111;
    localparam logic [4:0] OP_NOP  = 5'b11111;

    localparam logic [15:0] NOP_WORD = 16'hF800;

    typedef enum logic [2:0] {
        REQ1,
        CAP1,
        REQ2,
        CAP2,
        VALID
    } fetch_state_t;

    // Long instructions carry a second word (immediate or effective address).
    function automatic logic is_long(input logic [4:0] opcode);
        return (opcode == OP_LDM) || (opcode == OP_STD) || (opcode == OP_LDD);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads 16-bit words, assembles one- or two-word
// instructions and hands them to decode over a valid/ready handshake.
module fetch_unit
    import isa_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [15:0]       inst,
    output logic [15:0]       imm,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc;

    always_comb begin
        state_nxt = state;
        unique case (state)
            REQ1:    state_nxt = CAP1;
            CAP1:    state_nxt = is_long(imem_data[15:11]) ? REQ2 : VALID;
            REQ2:    state_nxt = CAP2;
            CAP2:    state_nxt = VALID;
            VALID:   if (inst_ready) state_nxt = REQ1;
            default: state_nxt = REQ1;
        endcase
        if (redirect) state_nxt = REQ1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= REQ1;
            pc      <= RESET_PC;
            inst    <= NOP_WORD;
            imm     <= '0;
            inst_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            // Redirect drops any word returning from memory this cycle.
            if (redirect) begin
                pc <= redirect_pc;
            end else if (state == CAP1) begin
                inst    <= imem_data;
                inst_pc <= pc;
                imm     <= '0;
                pc      <= pc + PC_ONE;
            end else if (state == CAP2) begin
                imm <= imem_data;
                pc  <= pc + PC_ONE;
            end
        end
    end

    // Reset parks the FSM in REQ1 but must not strobe memory until release.
    assign imem_rd    = rst_n && ((state == REQ1) || (state == REQ2));
    assign imem_addr  = pc;
    assign inst_valid = (state == VALID) && !redirect;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scoreboard of expected instructions from a
// program-walk model, plus a small ADDR_W=4 instance for PC wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [15:0] imem_data = '0;
    logic [15:0] inst;
    logic [15:0] imm;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;

    logic        s_rst_n = 1'b0;
    logic        s_rd;
    logic [3:0]  s_addr;
    logic [15:0] s_data = '0;
    logic [15:0] s_inst;
    logic [15:0] s_imm;
    logic [3:0]  s_pc;
    logic        s_valid;
    logic        s_ready = 1'b0;
    logic        s_redirect = 1'b0;
    logic [3:0]  s_rpc = '0;

    logic [15:0] mem  [65536];
    logic [15:0] mem4 [16];

    typedef struct {
        logic [15:0] inst;
        logic [15:0] imm;
        logic [15:0] pc;
        logic [15:0] nxt;
        bit          lng;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_req = 0;
    bit armed = 1'b0;
    bit chk_next = 1'b0;
    logic [15:0] next_exp = '0;

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0010)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_data(imem_data),
        .inst(inst), .imm(imm), .inst_pc(inst_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    fetch_unit #(.ADDR_W(4), .RESET_PC(4'hF)) u_small (
        .clk(clk), .rst_n(s_rst_n),
        .imem_rd(s_rd), .imem_addr(s_addr), .imem_data(s_data),
        .inst(s_inst), .imm(s_imm), .inst_pc(s_pc),
        .inst_valid(s_valid), .inst_ready(s_ready),
        .redirect(s_redirect), .redirect_pc(s_rpc)
    );

    always #5 clk = ~clk;

    // Memories with one-cycle read latency; garbage when not reading.
    always @(posedge clk) begin
        imem_data <= imem_rd ? mem[imem_addr] : 16'($urandom);
        s_data    <= s_rd ? mem4[s_addr] : 16'($urandom);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic bit ref_long(input logic [15:0] w);
        logic [4:0] op;
        op = w[15:11];
        return (op == 5'd7) || (op == 5'd14) || (op == 5'd15);
    endfunction

    // Program walk from start: what decode should see, in order.
    function automatic void push_stream(input logic [15:0] start);
        logic [15:0] p;
        exp_t e;
        exp_q.delete();
        p = start;
        for (int i = 0; i < 1024; i++) begin
            e.inst = mem[p];
            e.pc   = p;
            e.lng  = ref_long(mem[p]);
            e.imm  = e.lng ? mem[16'(p + 16'd1)] : 16'h0000;
            p      = e.lng ? 16'(p + 16'd2) : 16'(p + 16'd1);
            e.nxt  = p;
            exp_q.push_back(e);
        end
    endfunction

    // Monitor: samples on the falling edge, away from input changes.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            armed    = 1'b1;
            t_req    = cyc + 1;
            chk_next = 1'b1;
            next_exp = 16'h0010;
        end else begin
            if (chk_next) begin
                check("req1_rd", imem_rd, 1);
                check("req1_addr", imem_addr, next_exp);
                chk_next = 1'b0;
            end
            if (redirect) begin
                check("redirect_gate", inst_valid, 0);
                armed    = 1'b1;
                t_req    = cyc + 1;
                chk_next = 1'b1;
                next_exp = redirect_pc;
            end else if (inst_valid) begin
                check("valid_rd", imem_rd, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst act=%h exp=none", inst);
                end else begin
                    e = exp_q[0];
                    if (armed) begin
                        check("latency", 32'(cyc - t_req), e.lng ? 4 : 2);
                        armed = 1'b0;
                    end
                    check("inst", inst, e.inst);
                    check("imm", imm, e.imm);
                    check("inst_pc", inst_pc, e.pc);
                    if (inst_ready) begin
                        void'(exp_q.pop_front());
                        armed    = 1'b1;
                        t_req    = cyc + 1;
                        chk_next = 1'b1;
                        next_exp = e.nxt;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            step();
            if (inst_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_valid act=timeout exp=inst_valid");
    endtask

    initial begin
        logic [15:0] w;
        logic [4:0] lops [3];
        lops[0] = 5'd7;
        lops[1] = 5'd14;
        lops[2] = 5'd15;
        for (int i = 0; i < 65536; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 2) == 0) w[15:11] = lops[$urandom_range(0, 2)];
            mem[i] = w;
        end
        for (int i = 0; i < 16; i++) mem4[i] = 16'h1000;
        mem4[15] = 16'h7800;
        mem4[0]  = 16'hABCD;
        mem[16'h10] = 16'h0800;
        mem[16'h20] = 16'h3800;
        mem[16'h21] = 16'h1234;
        mem[16'h40] = 16'h3800;
        mem[16'h41] = 16'hBEEF;
        mem[16'h50] = 16'h1000;

        repeat (3) step();
        check("rst_inst", inst, 16'hF800);
        check("rst_imm", imm, 0);
        check("rst_pc", inst_pc, 16'h0010);
        check("rst_valid", inst_valid, 0);
        check("rst_rd", imem_rd, 0);

        // Narrow instance: LDD at the top address takes imm from 0.
        s_ready = 1'b1;
        s_rst_n = 1'b1;
        for (int i = 0; i < 20 && !s_valid; i++) step();
        check("wrap_inst", s_inst, 16'h7800);
        check("wrap_imm", s_imm, 16'hABCD);
        check("wrap_pc", s_pc, 4'hF);
        step();
        check("wrap_rd", s_rd, 1);
        check("wrap_next", s_addr, 4'h1);
        s_ready = 1'b0;

        push_stream(16'h0010);
        rst_n = 1'b1;
        #1;
        check("first_rd", imem_rd, 1);
        check("first_addr", imem_addr, 16'h0010);
        wait_valid();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;

        redirect = 1'b1;
        redirect_pc = 16'h0020;
        push_stream(16'h0020);
        step();
        redirect = 1'b0;
        wait_valid();
        repeat (5) step();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;

        wait_valid();
        inst_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        push_stream(16'h0040);
        #1;
        check("redir_valid", inst_valid, 0);
        step();
        redirect = 1'b0;
        check("redir_rd", imem_rd, 1);
        check("redir_addr", imem_addr, 16'h0040);
        step();
        step();
        check("req2_addr", imem_addr, 16'h0041);
        step();
        redirect = 1'b1;
        redirect_pc = 16'h0050;
        push_stream(16'h0050);
        step();
        redirect = 1'b0;
        wait_valid();
        check("cap2_imm", imm, 0);
        check("cap2_pc", inst_pc, 16'h0050);

        repeat (4000) begin
            step();
            inst_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 99) < 3) begin
                redirect = 1'b1;
                redirect_pc = 16'($urandom);
                push_stream(redirect_pc);
            end else begin
                redirect = 1'b0;
            end
        end
        step();
        redirect = 1'b0;
        inst_ready = 1'b0;
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage: the producer side of the 16-bit instruction word that the control_unit decodes.
- Reads 16-bit words from instruction memory and assembles one- or two-word instructions (LDM, STD and LDD carry a second word: an immediate or an effective address).
- Presents each instruction to decode over a valid/ready handshake.
- Accepts branch redirects from later stages.

Parameters:
- ADDR_W, 16, instruction-memory word-address width; PC wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_rd  out  1  read strobe to instruction memory.
- imem_addr  out  ADDR_W  word address for the read.
- imem_data  in  16  read data, valid the cycle after imem_rd (fixed 1-cycle latency).
- inst  out  16  first instruction word, to the control_unit.
- imm  out  16  second word of a long instruction; 0 for short instructions.
- inst_pc  out  ADDR_W  address of the first word of inst.
- inst_valid  out  1  inst/imm/inst_pc hold a valid instruction.
- inst_ready  in  1  decode accepts the instruction this cycle.
- redirect  in  1  branch/jump/call/ret/int taken; flush the stage.
- redirect_pc  in  ADDR_W  new fetch address.

Behaviour:
- Opcode = inst[15:11]. Long opcodes: LDM=00111, STD=01110, LDD=01111. All other opcodes are short.
- Reset (async, rst_n=0):
  - state=REQ1, pc=RESET_PC.
  - inst=16'hF800 (NOP), imm=0, inst_pc=RESET_PC, inst_valid=0, imem_rd=0.
  - Release takes effect at the next clock edge.
- REQ1: imem_rd=1, imem_addr=pc; next state CAP1.
- CAP1:
  - inst<=imem_data, inst_pc<=pc, imm<=0, pc<=pc+1.
  - If imem_data[15:11] is long, next state REQ2; otherwise next state VALID.
- REQ2: imem_rd=1, imem_addr=pc; next state CAP2.
- CAP2: imm<=imem_data, pc<=pc+1; next state VALID.
- VALID:
  - inst_valid = (state==VALID) && !redirect.
  - Handshake when inst_valid && inst_ready: next state REQ1.
  - Without a handshake, hold all outputs stable.
- imem_rd=0 in CAP1, CAP2 and VALID; imem_addr=pc in every state.
- Latency, measured from the REQ1 edge:
  - Short instruction: inst_valid asserts 2 cycles later.
  - Long instruction: inst_valid asserts 4 cycles later.
  - Maximum throughput is one short instruction per 3 cycles.
- Redirect has priority over everything, in any state:
  - Next edge: pc<=redirect_pc, state<=REQ1.
  - Any captured or in-flight word is discarded.
  - inst_valid is combinationally gated low in the redirect cycle, so no handshake can complete on a wrong-path instruction even if inst_ready=1.
- Redirect during CAP1/CAP2: the returning imem_data is dropped; inst and imm are not updated.
- PC wrap: pc+1 at 2^ADDR_W-1 gives 0. A long instruction whose first word is at the top address takes its imm from address 0.
- inst_ready while not VALID: ignored.
- Reset asserted mid-operation: immediate return to reset values; a pending memory read is ignored.

Decomposition:
- Shared package isa_pkg holds:
  - 5-bit opcode constants (OP_NOP=11111, OP_LDM, OP_STD, OP_LDD, etc.), reused by control_unit.
  - Function is_long(opcode).
  - NOP encoding constant 16'hF800.
  - Fetch state enum {REQ1, CAP1, REQ2, CAP2, VALID}.
- No sub-module; a single FSM with datapath registers.

Test Plan:
- Reset with RESET_PC=0x0010, then release -> imem_rd=1 with imem_addr=0x0010 on the first cycle; inst_valid=0 until memory returns data.
- mem[0x10]=0x0800 (SETC), inst_ready=1 -> inst_valid high 2 cycles after REQ1, inst=0x0800, imm=0, inst_pc=0x10; the next REQ1 addresses 0x11.
- mem[0x20]=0x3800 (LDM), mem[0x21]=0x1234 -> single handshake with inst=0x3800, imm=0x1234, inst_pc=0x20; the next fetch is from 0x22.
- Hold inst_ready=0 for 5 cycles in VALID -> inst, imm and inst_pc stay stable and imem_rd stays 0; raising inst_ready completes exactly one handshake.
- redirect=1 with redirect_pc=0x0040 while in VALID with inst_ready=1 -> inst_valid=0 in that cycle, no handshake; the next cycle shows REQ1 with imem_addr=0x40. Repeat with redirect in CAP2 -> the stale imm is not presented.
- ADDR_W=4, LDD at address 0xF -> imm is read from address 0x0, and the next fetch is from address 0x1.
